// File: rtl/seven_segment_mux.sv
// Multi-digit seven-segment driver: snapshots packed BCD digits on a load strobe and scans
// them onto a shared segment bus with a one-hot digit select.
module seven_segment_mux #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [4*DIGITS-1:0] counts,
   input  logic                blank_lz,
   input  logic                invert,
   output logic [6:0]          segments,
   output logic [DIGITS-1:0]   digit_sel
);

   localparam int unsigned PcW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PcW-1:0]  PcLast  = PcW'(PRESCALE - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

   logic [4*DIGITS-1:0] snap_q, snap_d;
   logic [PcW-1:0]      pc_q, pc_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   sel_q, sel_d;

   logic                pc_wrap;
   logic [3:0]          cur_digit;
   logic                cur_blank;
   logic                zero_run;

   // bit 6..0 = g..a; codes above 9 are blank
   function automatic logic [6:0] glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'd0:    g = 7'b0111111;
         4'd1:    g = 7'b0000110;
         4'd2:    g = 7'b1011011;
         4'd3:    g = 7'b1001111;
         4'd4:    g = 7'b1100110;
         4'd5:    g = 7'b1101101;
         4'd6:    g = 7'b1111100;
         4'd7:    g = 7'b0000111;
         4'd8:    g = 7'b1111111;
         4'd9:    g = 7'b1100111;
         default: g = 7'b0000000;
      endcase
      return g;
   endfunction

   always_comb begin
      snap_d = load ? counts : snap_q;

      pc_wrap = (pc_q == PcLast);
      pc_d    = pc_wrap ? '0 : pc_q + 1'b1;

      idx_d = idx_q;
      if (pc_wrap) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
   end

   // Walk from the most significant digit down so zero_run tells whether digit i and
   // everything above it is zero.
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (snap_q[4*i +: 4] == 4'd0);
         if (idx_q == IdxW'(i)) begin
            cur_digit = snap_q[4*i +: 4];
            cur_blank = blank_lz && zero_run && (i != 0);
         end
      end
   end

   always_comb begin
      seg_d = (cur_blank ? 7'b0000000 : glyph(cur_digit)) ^ {7{invert}};
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q <= '0;
         pc_q   <= '0;
         idx_q  <= '0;
         seg_q  <= 7'b0000000;
         sel_q  <= '0;
      end else begin
         snap_q <= snap_d;
         pc_q   <= pc_d;
         idx_q  <= idx_d;
         seg_q  <= seg_d;
         sel_q  <= sel_d;
      end
   end

   assign segments  = seg_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: a 4-digit/prescale-3 instance driven from a vector
// table plus hand sequences, and a 3-digit/prescale-1 instance for non-power-of-two scanning.
module tb_seven_segment_mux;

   logic        clk = 1'b0;
   logic        reset, load, blank_lz, invert;
   logic [15:0] counts;
   logic [6:0]  segments;
   logic [3:0]  digit_sel;

   logic        reset3, load3;
   logic [11:0] counts3;
   logic [6:0]  segments3;
   logic [2:0]  digit_sel3;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   seven_segment_mux #(.DIGITS(4), .PRESCALE(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .counts    (counts),
      .blank_lz  (blank_lz),
      .invert    (invert),
      .segments  (segments),
      .digit_sel (digit_sel)
   );

   seven_segment_mux #(.DIGITS(3), .PRESCALE(1)) u_dut3 (
      .clk       (clk),
      .reset     (reset3),
      .load      (load3),
      .counts    (counts3),
      .blank_lz  (1'b0),
      .invert    (1'b0),
      .segments  (segments3),
      .digit_sel (digit_sel3)
   );

   typedef struct {
      logic [15:0] counts;
      logic        blank;
      logic        inv;
      logic [3:0]  sel;
      logic [6:0]  seg;
   } vec_t;

   vec_t vecs[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
   endtask

   task automatic wait_sel(input logic [3:0] want);
      int n = 0;
      while (digit_sel !== want && n < 30) begin
         step();
         n++;
      end
      if (digit_sel !== want) check("wait_sel timeout", 32'(digit_sel), 32'(want));
   endtask

   task automatic load_pulse(input logic [15:0] value);
      counts = value;
      load   = 1'b1;
      step();
      load   = 1'b0;
      step();
   endtask

   initial begin
      logic [6:0] exp3 [3];
      exp3[0] = 7'b0000110;  // digit 0 = 1
      exp3[1] = 7'b1011011;  // digit 1 = 2
      exp3[2] = 7'b1001111;  // digit 2 = 3

      vecs.push_back('{16'h1234, 1'b0, 1'b0, 4'b0001, 7'b1100110});
      vecs.push_back('{16'h1234, 1'b0, 1'b0, 4'b0010, 7'b1001111});
      vecs.push_back('{16'h1234, 1'b0, 1'b0, 4'b0100, 7'b1011011});
      vecs.push_back('{16'h1234, 1'b0, 1'b0, 4'b1000, 7'b0000110});
      vecs.push_back('{16'h1234, 1'b0, 1'b1, 4'b0001, 7'b0011001});
      vecs.push_back('{16'h5678, 1'b0, 1'b0, 4'b1000, 7'b1101101});
      vecs.push_back('{16'h5678, 1'b0, 1'b0, 4'b0100, 7'b1111100});
      vecs.push_back('{16'h5678, 1'b0, 1'b0, 4'b0010, 7'b0000111});
      vecs.push_back('{16'h5678, 1'b0, 1'b0, 4'b0001, 7'b1111111});
      vecs.push_back('{16'h0050, 1'b1, 1'b0, 4'b1000, 7'b0000000});
      vecs.push_back('{16'h0050, 1'b1, 1'b0, 4'b0100, 7'b0000000});
      vecs.push_back('{16'h0050, 1'b1, 1'b0, 4'b0010, 7'b1101101});
      vecs.push_back('{16'h0050, 1'b1, 1'b0, 4'b0001, 7'b0111111});
      vecs.push_back('{16'h0050, 1'b0, 1'b0, 4'b1000, 7'b0111111});
      vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'b1000, 7'b0000000});
      vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'b0100, 7'b0000000});
      vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'b0010, 7'b0000000});
      vecs.push_back('{16'h0000, 1'b1, 1'b0, 4'b0001, 7'b0111111});
      vecs.push_back('{16'h0105, 1'b1, 1'b0, 4'b1000, 7'b0000000});
      vecs.push_back('{16'h0105, 1'b1, 1'b0, 4'b0100, 7'b0000110});
      vecs.push_back('{16'h0105, 1'b1, 1'b0, 4'b0010, 7'b0111111});
      vecs.push_back('{16'h0105, 1'b1, 1'b0, 4'b0001, 7'b1101101});
      vecs.push_back('{16'hA0F9, 1'b0, 1'b0, 4'b1000, 7'b0000000});
      vecs.push_back('{16'hA0F9, 1'b0, 1'b0, 4'b0100, 7'b0111111});
      vecs.push_back('{16'hA0F9, 1'b0, 1'b0, 4'b0010, 7'b0000000});
      vecs.push_back('{16'hA0F9, 1'b0, 1'b0, 4'b0001, 7'b1100111});

      reset    = 1'b1;
      load     = 1'b0;
      counts   = 16'h0000;
      blank_lz = 1'b0;
      invert   = 1'b1;
      reset3   = 1'b1;
      load3    = 1'b0;
      counts3  = 12'h000;

      // Reset clears outputs even with invert high
      step();
      step();
      check("reset segments", 32'(segments), 32'd0);
      check("reset digit_sel", 32'(digit_sel), 32'd0);

      // Scan order after release: each digit held for 3 cycles
      reset  = 1'b0;
      invert = 1'b0;
      for (int k = 0; k < 13; k++) begin
         step();
         check($sformatf("scan cycle %0d", k), 32'(digit_sel), 32'(4'b0001 << ((k / 3) % 4)));
      end

      foreach (vecs[v]) begin
         blank_lz = vecs[v].blank;
         invert   = vecs[v].inv;
         load_pulse(vecs[v].counts);
         wait_sel(vecs[v].sel);
         check($sformatf("vec %0d counts %h sel %b", v, vecs[v].counts, vecs[v].sel),
               32'(segments), 32'(vecs[v].seg));
      end

      // Invert toggled mid-dwell takes effect on the next cycle
      blank_lz = 1'b0;
      invert   = 1'b0;
      load_pulse(16'h1234);
      wait_sel(4'b1000);
      wait_sel(4'b0001);
      check("dwell0 seg", 32'(segments), 32'b1100110);
      invert = 1'b1;
      step();
      check("invert on sel", 32'(digit_sel), 32'b0001);
      check("invert on seg", 32'(segments), 32'b0011001);
      invert = 1'b0;
      step();
      check("invert off sel", 32'(digit_sel), 32'b0001);
      check("invert off seg", 32'(segments), 32'b1100110);

      // Load on the same edge the scan advances from digit 0 to digit 1
      wait_sel(4'b1000);
      wait_sel(4'b0001);
      step();
      counts = 16'h9876;
      load   = 1'b1;
      step();
      load   = 1'b0;
      check("race old sel", 32'(digit_sel), 32'b0001);
      check("race old seg", 32'(segments), 32'b1100110);
      step();
      check("race new sel", 32'(digit_sel), 32'b0010);
      check("race new seg", 32'(segments), 32'b0000111);

      // Reset mid-frame restarts the scan and loses the snapshot
      wait_sel(4'b0100);
      reset = 1'b1;
      step();
      check("midreset sel", 32'(digit_sel), 32'd0);
      check("midreset seg", 32'(segments), 32'd0);
      reset = 1'b0;
      step();
      check("restart sel", 32'(digit_sel), 32'b0001);
      check("restart seg", 32'(segments), 32'b0111111);
      step();
      step();
      step();
      check("restart next sel", 32'(digit_sel), 32'b0010);

      // Three-digit instance with prescale 1: never selects a fourth digit
      reset3  = 1'b0;
      load3   = 1'b1;
      counts3 = 12'h321;
      for (int k = 0; k < 9; k++) begin
         step();
         check($sformatf("d3 sel %0d", k), 32'(digit_sel3), 32'(3'b001 << (k % 3)));
         if (k == 0) check("d3 seg 0", 32'(segments3), 32'b0111111);
         else check($sformatf("d3 seg %0d", k), 32'(segments3), 32'(exp3[k % 3]));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multi-digit seven-segment display driver for the frequency-counter output path. It captures a packed vector of BCD digits on a load strobe and time-multiplexes them onto one shared 7-bit segment bus with a one-hot digit select. Dwell time per digit is programmable. It supports optional leading-zero blanking and runtime output inversion. It replaces the fixed two-digit, every-cycle-toggle driver.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, 2..8.
- `PRESCALE`, default 1: clock cycles each digit is held, 1..65535.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load` input 1: when high, `counts` is captured into the snapshot register.
- `counts` input 4*DIGITS: packed BCD digits; bits [3:0] are digit 0 (units), and [4i+3:4i] is digit i.
- `blank_lz` input 1: when high, leading zeros are blanked.
- `invert` input 1: when high, the segment output is inverted (common-anode panels).
- `segments` output 7: registered segment pattern; bit 0 = segment a … bit 6 = segment g.
- `digit_sel` output DIGITS: registered one-hot digit enable, active-high.

## Operation
- Snapshot: a register of 4*DIGITS bits.
  - Loads `counts` on any cycle with `load`=1.
  - Holds its value otherwise.
  - Only the snapshot is displayed; `counts` may change freely between loads.
- Prescale counter `pc`:
  - Width is clog2(PRESCALE), minimum 1.
  - Counts 0..PRESCALE-1 and wraps to 0.
  - With PRESCALE=1 it is effectively always 0.
- Scan index `idx`:
  - Width is clog2(DIGITS), minimum 1.
  - Advances when `pc`==PRESCALE-1, in the order 0,1,…,DIGITS-1, then wraps to 0.
  - Values ≥ DIGITS never occur, including for DIGITS that are not powers of two.
- Glyph table for 4-bit code → abcdefg (bit6..bit0 = g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111
  - codes 10–15 = 0000000 (blank)
- Leading-zero blanking: digit i>0 is blanked (pattern 0000000) when `blank_lz`=1 and snapshot digits i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Output register, updated every cycle when not in reset:
  - `digit_sel` <= 1<<idx.
  - `segments` <= glyph(snapshot digit idx), after blanking, XOR {7{`invert`}}.
  - Both outputs are always written together, so the pattern and the select belong to the same digit in every cycle.
- Outputs never change combinationally with any input.

## Timing
- Reset (synchronous, takes priority over `load` and scanning):
  - Snapshot, `pc` and `idx` clear to 0.
  - `segments` = 7'b0000000 and `digit_sel` = all zeros, regardless of `invert`.
- First cycle after reset deasserts: the outputs register digit 0, so `digit_sel`=…0001 on the next edge.
- Scan latency: `idx` → outputs is 1 cycle. Each digit is visible for exactly PRESCALE consecutive cycles. One full frame lasts DIGITS*PRESCALE cycles.
- Load latency: `load` at edge N updates the snapshot. The new value is seen by the output register at edge N+1, whichever digit is currently selected. No frame alignment is applied.
- Simultaneous `load` and scan advance: both take effect. The newly selected digit shows the new data.
- `invert` and `blank_lz` changes reach `segments` one cycle later.
- Reset mid-frame: the scan restarts at digit 0 and the snapshot is lost. Behaviour is identical to power-on reset.

## Test plan
- Reset: DIGITS=4, PRESCALE=3, hold `reset` for 2 cycles → `segments`=0000000, `digit_sel`=0000. On release, `digit_sel` is 0001 for 3 cycles, then 0010, 0100, 1000, 0001 (frame = 12 cycles).
- Display: load `counts`=16'h1234, `blank_lz`=0 → when `digit_sel`=0001 `segments`=1100110 (4); 0010 → 1001111; 0100 → 1011011; 1000 → 0000110.
- Invert: same data with `invert`=1 → digit 0 `segments`=0011001. Toggling `invert` mid-dwell flips the output on the next cycle.
- Blanking: `counts`=16'h0050, `blank_lz`=1 → digits 3 and 2 = 0000000, digit 1 = 1101101, digit 0 = 0111111. `counts`=0000 → only digit 0 shows 0111111.
- Invalid codes: `counts`=16'hA0F9 → digits 3 and 1 blank, digit 2 = 0111111, digit 0 = 1100111. Also check with DIGITS=3, PRESCALE=1: `idx` cycles 0,1,2 and never selects a 4th digit.
- Load and reset races: pulse `load` on the same edge the scan advances → the new digit shows new data immediately. Assert `reset` while `digit_sel`=0100 → outputs clear next edge and the scan restarts at 0001.
